wbu_l2w_sink: RTL and testbench

- Receiving end of the LSU→WBU stage interface: the write-back unit's input side.
- Accepts the LSU→WBU bundle over a valid/ready handshake and buffers it in a 2-entry FIFO.
- Selects the write-back data from the register-write source and drives the GPR write port, which has its own ready.
- Emits a commit pulse per retired instruction and keeps a retired-instruction counter.

---
 rtl/wbu_l2w_sink_if.sv | 41 ++++
 rtl/wbu_l2w_sink.sv | 132 +++++++++++++
 tb/tb_wbu_l2w_sink.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wbu_l2w_sink_if.sv
// LSU->WBU bundle, GPR write port and commit outputs of the write-back sink.
interface wbu_l2w_sink_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int GPRS_WIDTH = 5,
   parameter int ARGS_WIDTH = 2,
   parameter int CNT_WIDTH  = 64
);
   logic                  i_l2w_valid;
   logic                  o_wbu_ready;
   logic                  i_l2w_ctr_reg_wr_en;
   logic [ARGS_WIDTH-1:0] i_l2w_ctr_reg_wr_src;
   logic [ADDR_WIDTH-1:0] i_l2w_pc;
   logic [DATA_WIDTH-1:0] i_l2w_alu_res;
   logic [DATA_WIDTH-1:0] i_l2w_ram_res;
   logic [GPRS_WIDTH-1:0] i_l2w_gpr_wr_id;
   logic                  i_wbu_flush;
   logic                  o_gpr_wr_en;
   logic [GPRS_WIDTH-1:0] o_gpr_wr_id;
   logic [DATA_WIDTH-1:0] o_gpr_wr_data;
   logic                  i_gpr_wr_ready;
   logic                  o_cmt_valid;
   logic [ADDR_WIDTH-1:0] o_cmt_pc;
   logic [CNT_WIDTH-1:0]  o_cmt_cnt;

   // Upstream LSU / GPR file / commit consumer side.
   modport master (
      output i_l2w_valid, i_l2w_ctr_reg_wr_en, i_l2w_ctr_reg_wr_src, i_l2w_pc,
             i_l2w_alu_res, i_l2w_ram_res, i_l2w_gpr_wr_id, i_wbu_flush, i_gpr_wr_ready,
      input  o_wbu_ready, o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
             o_cmt_valid, o_cmt_pc, o_cmt_cnt
   );

   // Write-back unit side.
   modport slave (
      input  i_l2w_valid, i_l2w_ctr_reg_wr_en, i_l2w_ctr_reg_wr_src, i_l2w_pc,
             i_l2w_alu_res, i_l2w_ram_res, i_l2w_gpr_wr_id, i_wbu_flush, i_gpr_wr_ready,
      output o_wbu_ready, o_gpr_wr_en, o_gpr_wr_id, o_gpr_wr_data,
             o_cmt_valid, o_cmt_pc, o_cmt_cnt
   );
endinterface

// File: rtl/wbu_l2w_sink.sv
// Write-back unit input: 2-entry bundle FIFO, GPR write port, commit pulse/counter.
module wbu_l2w_sink #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int GPRS_WIDTH = 5,
   parameter int ARGS_WIDTH = 2,
   parameter int CNT_WIDTH  = 64
) (
   input  logic             i_sys_clk,
   input  logic             i_sys_rst_n,
   wbu_l2w_sink_if.slave    bus
);

   typedef struct packed {
      logic                  wr_en;
      logic [ARGS_WIDTH-1:0] wr_src;
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] alu_res;
      logic [DATA_WIDTH-1:0] ram_res;
      logic [GPRS_WIDTH-1:0] gpr_wr_id;
   } entry_t;

   entry_t                mem_q [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  rdy_q, rdy_d;
   logic                  cmt_vld_q;
   logic [ADDR_WIDTH-1:0] cmt_pc_q;
   logic [CNT_WIDTH-1:0]  cmt_cnt_q;

   entry_t                head;
   entry_t                in_ent;
   logic                  head_vld;
   logic                  wr_need;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head_data;

   assign head     = mem_q[rd_ptr_q];
   assign head_vld = (cnt_q != 2'd0);
   // x0 writes are dropped here but the instruction still retires.
   assign wr_need  = head.wr_en && (head.gpr_wr_id != '0);
   // Flush cancels both sides of the handshake in its cycle.
   assign push     = bus.i_l2w_valid && rdy_q && !bus.i_wbu_flush;
   assign pop      = head_vld && (!wr_need || bus.i_gpr_wr_ready) && !bus.i_wbu_flush;

   assign in_ent = '{wr_en:     bus.i_l2w_ctr_reg_wr_en,
                     wr_src:    bus.i_l2w_ctr_reg_wr_src,
                     pc:        bus.i_l2w_pc,
                     alu_res:   bus.i_l2w_alu_res,
                     ram_res:   bus.i_l2w_ram_res,
                     gpr_wr_id: bus.i_l2w_gpr_wr_id};

   // Write-back data select from the head's register-write source; unknown codes give zero.
   always_comb begin
      head_data = '0;
      case (head.wr_src)
         ARGS_WIDTH'(1): head_data = head.alu_res;
         ARGS_WIDTH'(2): head_data = head.ram_res;
         ARGS_WIDTH'(3): head_data = DATA_WIDTH'(head.pc + ADDR_WIDTH'(4));
         default:        head_data = '0;
      endcase
   end

   // Next pointer/count state; ready is registered from the next count so it never sees gpr ready.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (bus.i_wbu_flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         if (push && !pop)      cnt_d = cnt_q + 2'd1;
         else if (pop && !push) cnt_d = cnt_q - 2'd1;
      end
      rdy_d = (cnt_d != 2'd2);
   end

   // FIFO control state.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         rdy_q    <= 1'b1;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         rdy_q    <= rdy_d;
      end
   end

   // FIFO storage, written on accepted bundles only.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= in_ent;
      end
   end

   // Commit pulse, PC of the retired instruction and wrapping retire counter.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         cmt_vld_q <= 1'b0;
         cmt_pc_q  <= '0;
         cmt_cnt_q <= '0;
      end else begin
         cmt_vld_q <= pop;
         if (pop) begin
            cmt_pc_q  <= head.pc;
            cmt_cnt_q <= cmt_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.o_wbu_ready   = rdy_q;
   assign bus.o_gpr_wr_en   = head_vld && wr_need;
   assign bus.o_gpr_wr_id   = head_vld ? head.gpr_wr_id : '0;
   assign bus.o_gpr_wr_data = head_vld ? head_data : '0;
   assign bus.o_cmt_valid   = cmt_vld_q;
   assign bus.o_cmt_pc      = cmt_pc_q;
   assign bus.o_cmt_cnt     = cmt_cnt_q;

endmodule

// File: tb/tb_wbu_l2w_sink.sv
// Directed test of the write-back sink: latency, source select, backpressure, x0, flush, wrap, reset.
module tb_wbu_l2w_sink;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ncmp = 0;
   int   nerr = 0;

   wbu_l2w_sink_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .GPRS_WIDTH(5), .ARGS_WIDTH(2), .CNT_WIDTH(64)) bus ();

   wbu_l2w_sink #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .GPRS_WIDTH(5), .ARGS_WIDTH(2), .CNT_WIDTH(64)) dut (
      .i_sys_clk   (clk),
      .i_sys_rst_n (rst_n),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs and checks happen 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one bundle for one cycle; it is accepted if ready was high before the edge.
   task automatic send(input logic en, input logic [1:0] src, input logic [4:0] id,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ram);
      bus.i_l2w_valid          = 1'b1;
      bus.i_l2w_ctr_reg_wr_en  = en;
      bus.i_l2w_ctr_reg_wr_src = src;
      bus.i_l2w_gpr_wr_id      = id;
      bus.i_l2w_pc             = pc;
      bus.i_l2w_alu_res        = alu;
      bus.i_l2w_ram_res        = ram;
      step();
      bus.i_l2w_valid = 1'b0;
   endtask

   initial begin
      bus.i_l2w_valid = 0; bus.i_l2w_ctr_reg_wr_en = 0; bus.i_l2w_ctr_reg_wr_src = 0;
      bus.i_l2w_pc = 0; bus.i_l2w_alu_res = 0; bus.i_l2w_ram_res = 0; bus.i_l2w_gpr_wr_id = 0;
      bus.i_wbu_flush = 0; bus.i_gpr_wr_ready = 0;

      // Reset values
      repeat (2) step();
      chk("rst_ready", 64'(bus.o_wbu_ready), 64'd1);
      chk("rst_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      chk("rst_wr_id", 64'(bus.o_gpr_wr_id), 64'd0);
      chk("rst_wr_data", 64'(bus.o_gpr_wr_data), 64'd0);
      chk("rst_cmt_valid", 64'(bus.o_cmt_valid), 64'd0);
      chk("rst_cmt_pc", 64'(bus.o_cmt_pc), 64'd0);
      chk("rst_cmt_cnt", bus.o_cmt_cnt, 64'd0);
      rst_n = 1'b1;
      step();

      // Single bundle, ALU source, minimum latency
      bus.i_gpr_wr_ready = 1'b1;
      send(1, 2'd1, 5'd5, 32'h8000_0000, 32'h1234, 32'h0);
      chk("first_wr_en", 64'(bus.o_gpr_wr_en), 64'd1);
      chk("first_wr_id", 64'(bus.o_gpr_wr_id), 64'd5);
      chk("first_wr_data", 64'(bus.o_gpr_wr_data), 64'h1234);
      chk("first_no_cmt_yet", 64'(bus.o_cmt_valid), 64'd0);
      step();
      chk("first_cmt_valid", 64'(bus.o_cmt_valid), 64'd1);
      chk("first_cmt_pc", 64'(bus.o_cmt_pc), 64'h8000_0000);
      chk("first_cmt_cnt", bus.o_cmt_cnt, 64'd1);
      chk("first_empty_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      step();
      chk("cmt_pulse_ends", 64'(bus.o_cmt_valid), 64'd0);
      chk("cmt_pc_holds", 64'(bus.o_cmt_pc), 64'h8000_0000);

      // Source select: RAM, PC+4, zero
      send(1, 2'd2, 5'd6, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF);
      chk("src_ram_data", 64'(bus.o_gpr_wr_data), 64'hDEAD_BEEF);
      chk("src_ram_id", 64'(bus.o_gpr_wr_id), 64'd6);
      send(1, 2'd3, 5'd7, 32'h8000_0010, 32'h5555, 32'h6666);
      chk("src_pc4_data", 64'(bus.o_gpr_wr_data), 64'h8000_0014);
      send(1, 2'd0, 5'd8, 32'h8000_0020, 32'h7777, 32'h8888);
      chk("src_zero_data", 64'(bus.o_gpr_wr_data), 64'd0);
      chk("src_zero_wr_en", 64'(bus.o_gpr_wr_en), 64'd1);
      step();
      chk("src_cmt_pc", 64'(bus.o_cmt_pc), 64'h8000_0020);
      chk("src_cmt_cnt", bus.o_cmt_cnt, 64'd4);

      // Backpressure: three offered, two accepted, head stable
      bus.i_gpr_wr_ready = 1'b0;
      send(1, 2'd1, 5'd9, 32'h100, 32'hA, 32'h0);
      chk("bp_ready_one", 64'(bus.o_wbu_ready), 64'd1);
      send(1, 2'd1, 5'd10, 32'h104, 32'hB, 32'h0);
      chk("bp_ready_full", 64'(bus.o_wbu_ready), 64'd0);
      chk("bp_wr_en", 64'(bus.o_gpr_wr_en), 64'd1);
      chk("bp_id_a", 64'(bus.o_gpr_wr_id), 64'd9);
      send(1, 2'd1, 5'd11, 32'h108, 32'hC, 32'h0);
      bus.i_l2w_valid = 1'b1;                     // keep C on offer
      chk("bp_still_full", 64'(bus.o_wbu_ready), 64'd0);
      chk("bp_id_stable", 64'(bus.o_gpr_wr_id), 64'd9);
      chk("bp_data_stable", 64'(bus.o_gpr_wr_data), 64'hA);
      chk("bp_no_cmt", 64'(bus.o_cmt_valid), 64'd0);
      bus.i_gpr_wr_ready = 1'b1;
      step();                                     // pop A, C refused (was full)
      chk("bp_cmt_a", 64'(bus.o_cmt_pc), 64'h100);
      chk("bp_head_b", 64'(bus.o_gpr_wr_data), 64'hB);
      chk("bp_ready_back", 64'(bus.o_wbu_ready), 64'd1);
      step();                                     // pop B, push C
      bus.i_l2w_valid = 1'b0;
      chk("bp_cmt_b", 64'(bus.o_cmt_pc), 64'h104);
      chk("bp_head_c", 64'(bus.o_gpr_wr_data), 64'hC);
      step();
      chk("bp_cmt_c", 64'(bus.o_cmt_pc), 64'h108);
      chk("bp_cmt_cnt", bus.o_cmt_cnt, 64'd7);

      // x0 and no-write bundles retire without a GPR write
      bus.i_gpr_wr_ready = 1'b0;
      send(1, 2'd1, 5'd0, 32'h200, 32'h55, 32'h0);
      chk("x0_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      send(0, 2'd1, 5'd7, 32'h204, 32'h66, 32'h0);
      chk("nowr_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      chk("x0_cmt_pc", 64'(bus.o_cmt_pc), 64'h200);
      step();
      chk("nowr_cmt_pc", 64'(bus.o_cmt_pc), 64'h204);
      chk("nowr_cmt_cnt", bus.o_cmt_cnt, 64'd9);
      step();

      // Flush with two entries; pop and push in the flush cycle are cancelled
      send(1, 2'd1, 5'd3, 32'h300, 32'h1, 32'h0);
      send(1, 2'd1, 5'd4, 32'h304, 32'h2, 32'h0);
      chk("fl_full", 64'(bus.o_wbu_ready), 64'd0);
      bus.i_wbu_flush = 1'b1;
      bus.i_gpr_wr_ready = 1'b1;
      bus.i_l2w_valid = 1'b1;
      step();
      bus.i_wbu_flush = 1'b0;
      bus.i_l2w_valid = 1'b0;
      chk("fl_ready", 64'(bus.o_wbu_ready), 64'd1);
      chk("fl_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      chk("fl_no_cmt", 64'(bus.o_cmt_valid), 64'd0);
      chk("fl_cnt", bus.o_cmt_cnt, 64'd9);
      step();
      chk("fl_no_cmt_later", 64'(bus.o_cmt_valid), 64'd0);
      chk("fl_cnt_later", bus.o_cmt_cnt, 64'd9);

      // Counter wrap from all-ones
      force dut.cmt_cnt_q = '1;
      #1;
      release dut.cmt_cnt_q;
      chk("wrap_preload", bus.o_cmt_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      send(1, 2'd1, 5'd1, 32'h400, 32'h9, 32'h0);
      step();
      chk("wrap_cmt_valid", 64'(bus.o_cmt_valid), 64'd1);
      chk("wrap_cnt", bus.o_cmt_cnt, 64'd0);
      send(1, 2'd1, 5'd1, 32'h404, 32'h9, 32'h0);
      step();
      chk("post_wrap_cnt", bus.o_cmt_cnt, 64'd1);

      // Async reset mid-stream, between clock edges
      bus.i_gpr_wr_ready = 1'b0;
      send(1, 2'd1, 5'd12, 32'h500, 32'hE, 32'h0);
      send(1, 2'd1, 5'd13, 32'h504, 32'hF, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", 64'(bus.o_wbu_ready), 64'd1);
      chk("arst_wr_en", 64'(bus.o_gpr_wr_en), 64'd0);
      chk("arst_wr_id", 64'(bus.o_gpr_wr_id), 64'd0);
      chk("arst_wr_data", 64'(bus.o_gpr_wr_data), 64'd0);
      chk("arst_cmt_pc", 64'(bus.o_cmt_pc), 64'd0);
      chk("arst_cnt", bus.o_cmt_cnt, 64'd0);
      step();
      rst_n = 1'b1;
      bus.i_gpr_wr_ready = 1'b1;
      step();
      step();
      chk("arst_discard_cmt", 64'(bus.o_cmt_valid), 64'd0);
      chk("arst_discard_cnt", bus.o_cmt_cnt, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
